// File: rtl/wt_cache_pkg.sv
// Shared types for the dcache read-port arbiter: request/response structs, FSM states and limits.
package wt_cache_pkg;

    localparam int unsigned RD_ARB_MAX_REQ     = 8;
    localparam int unsigned DCACHE_INDEX_WIDTH = 12;
    localparam int unsigned DCACHE_TAG_WIDTH   = 44;
    localparam int unsigned DCACHE_DATA_WIDTH  = 64;

    typedef enum logic [1:0] {
        RD_ARB_IDLE,
        RD_ARB_TAG,
        RD_ARB_RESP
    } rd_arb_state_e;

    typedef struct packed {
        logic [DCACHE_INDEX_WIDTH-1:0]  address_index;
        logic [DCACHE_TAG_WIDTH-1:0]    address_tag;
        logic [DCACHE_DATA_WIDTH-1:0]   data_wdata;
        logic                           data_req;
        logic                           data_we;
        logic [DCACHE_DATA_WIDTH/8-1:0] data_be;
        logic [1:0]                     data_size;
        logic                           kill_req;
        logic                           tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic                         data_gnt;
        logic                         data_rvalid;
        logic [DCACHE_DATA_WIDTH-1:0] data_rdata;
    } dcache_req_o_t;

    // Requester id width; a 2-port arbiter still needs one bit.
    function automatic int unsigned rd_arb_id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wt_dcache_rd_arb_sel.sv
// Combinational winner selection: round-robin from rr_ptr_i, overridden by starving ports,
// overridden in turn by a held lock while the locked requester keeps asking.
module wt_dcache_rd_arb_sel #(
    parameter int unsigned NumReq = 2,
    parameter int unsigned IdW    = 1
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdW-1:0]    rr_ptr_i,
    input  logic              lock_vld_i,
    input  logic [IdW-1:0]    lock_id_i,
    input  logic [NumReq-1:0] starve_i,
    output logic [IdW-1:0]    id_o,
    output logic              valid_o
);

    logic [IdW:0]      sum;
    logic [IdW-1:0]    idx;
    logic [NumReq-1:0] starving;

    always_comb begin
        id_o     = '0;
        valid_o  = 1'b0;
        sum      = '0;
        idx      = '0;
        starving = starve_i & req_i;

        // Walk backwards so the first requester at or above rr_ptr_i is the last one written.
        for (int i = NumReq - 1; i >= 0; i--) begin
            sum = {1'b0, rr_ptr_i} + (IdW + 1)'(i);
            if (sum >= (IdW + 1)'(NumReq)) begin
                sum = sum - (IdW + 1)'(NumReq);
            end
            idx = sum[IdW-1:0];
            if (req_i[idx]) begin
                id_o    = idx;
                valid_o = 1'b1;
            end
        end

        if (|starving) begin
            for (int i = NumReq - 1; i >= 0; i--) begin
                if (starving[i]) begin
                    id_o = IdW'(i);
                end
            end
        end

        if (lock_vld_i && req_i[lock_id_i]) begin
            id_o    = lock_id_i;
            valid_o = 1'b1;
        end
    end

endmodule

// File: rtl/wt_dcache_rd_arbiter.sv
// Shares one dcache read-controller port among NumReq requesters with round-robin arbitration.
// Optional starvation guard enabled by defining WT_DCACHE_RD_ARB_STARVE_EN.
module wt_dcache_rd_arbiter
    import wt_cache_pkg::*;
#(
    parameter int unsigned NumReq  = 2,
    parameter int unsigned MaxWait = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  dcache_req_i_t [NumReq-1:0] req_ports_i,
    output dcache_req_o_t [NumReq-1:0] req_ports_o,
    output dcache_req_i_t              cache_port_o,
    input  dcache_req_o_t              cache_port_i,
    output logic                       busy_o
);

    localparam int unsigned IdW = rd_arb_id_width(NumReq);

    if (NumReq < 2 || NumReq > RD_ARB_MAX_REQ) begin : gen_bad_num_req
        $error("wt_dcache_rd_arbiter: NumReq must be 2..8");
    end
    if (MaxWait < 2 || MaxWait > 255) begin : gen_bad_max_wait
        $error("wt_dcache_rd_arbiter: MaxWait must be 2..255");
    end

    rd_arb_state_e     state_q;
    logic [IdW-1:0]    owner_q;
    logic [IdW-1:0]    rr_ptr_q;
    logic              lock_vld_q;
    logic [IdW-1:0]    lock_id_q;

    logic [NumReq-1:0] req_mask;
    logic [NumReq-1:0] starve;
    logic [IdW-1:0]    win_id;
    logic              win_valid;
    logic [IdW-1:0]    win_next;

    always_comb begin
        req_mask = '0;
        for (int i = 0; i < NumReq; i++) begin
            req_mask[i] = req_ports_i[i].data_req;
        end
    end

    wt_dcache_rd_arb_sel #(
        .NumReq (NumReq),
        .IdW    (IdW)
    ) u_sel (
        .req_i      (req_mask),
        .rr_ptr_i   (rr_ptr_q),
        .lock_vld_i (lock_vld_q),
        .lock_id_i  (lock_id_q),
        .starve_i   (starve),
        .id_o       (win_id),
        .valid_o    (win_valid)
    );

    assign win_next = (win_id == IdW'(NumReq - 1)) ? '0 : win_id + IdW'(1);
    assign busy_o   = (state_q != RD_ARB_IDLE);

    // Routing is gated by reset so nothing leaks out while the FSM is held.
    always_comb begin
        cache_port_o = '0;
        req_ports_o  = '0;
        for (int i = 0; i < NumReq; i++) begin
            req_ports_o[i].data_rdata = cache_port_i.data_rdata;
        end
        if (!rst_i) begin
            case (state_q)
                RD_ARB_IDLE: begin
                    if (win_valid) begin
                        cache_port_o                 = req_ports_i[win_id];
                        req_ports_o[win_id].data_gnt = cache_port_i.data_gnt;
                    end
                end
                RD_ARB_TAG: begin
                    cache_port_o.tag_valid   = req_ports_i[owner_q].tag_valid;
                    cache_port_o.kill_req    = req_ports_i[owner_q].kill_req;
                    cache_port_o.address_tag = req_ports_i[owner_q].address_tag;
                    if (!req_ports_i[owner_q].kill_req && req_ports_i[owner_q].tag_valid) begin
                        req_ports_o[owner_q].data_rvalid = cache_port_i.data_rvalid;
                    end
                end
                RD_ARB_RESP: begin
                    cache_port_o.kill_req            = req_ports_i[owner_q].kill_req;
                    req_ports_o[owner_q].data_rvalid = cache_port_i.data_rvalid;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= RD_ARB_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            lock_vld_q <= 1'b0;
            lock_id_q  <= '0;
        end else begin
            case (state_q)
                RD_ARB_IDLE: begin
                    if (win_valid) begin
                        if (cache_port_i.data_gnt) begin
                            owner_q    <= win_id;
                            rr_ptr_q   <= win_next;
                            lock_vld_q <= 1'b0;
                            state_q    <= RD_ARB_TAG;
                        end else begin
                            lock_vld_q <= 1'b1;
                            lock_id_q  <= win_id;
                        end
                    end else begin
                        lock_vld_q <= 1'b0;
                    end
                end
                RD_ARB_TAG: begin
                    if (req_ports_i[owner_q].kill_req) begin
                        state_q <= RD_ARB_IDLE;
                    end else if (req_ports_i[owner_q].tag_valid) begin
                        state_q <= cache_port_i.data_rvalid ? RD_ARB_IDLE : RD_ARB_RESP;
                    end
                end
                RD_ARB_RESP: begin
                    if (cache_port_i.data_rvalid) begin
                        state_q <= RD_ARB_IDLE;
                    end
                end
                default: state_q <= RD_ARB_IDLE;
            endcase
        end
    end

`ifdef WT_DCACHE_RD_ARB_STARVE_EN
    logic [7:0] wait_cnt_q [NumReq];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumReq; i++) begin
                wait_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumReq; i++) begin
                if (!req_mask[i] || req_ports_o[i].data_gnt) begin
                    wait_cnt_q[i] <= '0;
                end else if (wait_cnt_q[i] != 8'hff) begin
                    wait_cnt_q[i] <= wait_cnt_q[i] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        starve = '0;
        for (int i = 0; i < NumReq; i++) begin
            starve[i] = (wait_cnt_q[i] >= 8'(MaxWait));
        end
    end
`else
    assign starve = '0;
`endif

    // A response with no transaction in flight has nowhere to go and is dropped.
    rvalid_while_idle: assert property (@(posedge clk_i) disable iff (rst_i)
        !(state_q == RD_ARB_IDLE && cache_port_i.data_rvalid));

endmodule

// File: tb/tb_wt_dcache_rd_arbiter.sv
// Directed self-checking bench for wt_dcache_rd_arbiter; the starvation scenario needs
// WT_DCACHE_RD_ARB_STARVE_EN and then runs with three ports.
module tb_wt_dcache_rd_arbiter;
    import wt_cache_pkg::*;

`ifdef WT_DCACHE_RD_ARB_STARVE_EN
    localparam int unsigned NREQ  = 3;
    localparam int unsigned MWAIT = 4;
`else
    localparam int unsigned NREQ  = 2;
    localparam int unsigned MWAIT = 16;
`endif

    logic                     clk_i = 1'b0;
    logic                     rst_i = 1'b1;
    dcache_req_i_t [NREQ-1:0] req_i;
    dcache_req_o_t [NREQ-1:0] rsp_o;
    dcache_req_i_t            cache_o;
    dcache_req_o_t            cache_i;
    logic                     busy;

    int checks = 0;
    int passed = 0;

    wt_dcache_rd_arbiter #(
        .NumReq  (NREQ),
        .MaxWait (MWAIT)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_ports_i  (req_i),
        .req_ports_o  (rsp_o),
        .cache_port_o (cache_o),
        .cache_port_i (cache_i),
        .busy_o       (busy)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [NREQ-1:0] gnts();
        logic [NREQ-1:0] v;
        for (int i = 0; i < NREQ; i++) v[i] = rsp_o[i].data_gnt;
        return v;
    endfunction

    function automatic logic [NREQ-1:0] rvs();
        logic [NREQ-1:0] v;
        for (int i = 0; i < NREQ; i++) v[i] = rsp_o[i].data_rvalid;
        return v;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int k);
        logic [NREQ-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        rst_i   = 1'b1;
        cache_i = '0;
        req_i   = '0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [NREQ-1:0] z;
        z       = '0;
        rst_i   = 1'b1;
        cache_i = '0;
        cache_i.data_gnt = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_i[i] = '0;
            req_i[i].data_req = 1'b1;
            req_i[i].address_index = DCACHE_INDEX_WIDTH'(i + 1);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            checks++; if (gnts() !== z) $display("FAIL rst_gnt: got %b want %b", gnts(), z); else passed++;
            checks++; if (cache_o.data_req !== 1'b0) $display("FAIL rst_cache_req: got %b want 0", cache_o.data_req); else passed++;
            checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
        end
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        checks++; if (gnts() !== onehot(0)) $display("FAIL rst_first_gnt: got %b want %b", gnts(), onehot(0)); else passed++;
        checks++; if (cache_o.address_index !== 12'h001) $display("FAIL rst_first_idx: got %h want 001", cache_o.address_index); else passed++;
        tick();
        for (int i = 0; i < NREQ; i++) req_i[i].data_req = 1'b0;
        req_i[0].tag_valid   = 1'b1;
        cache_i.data_rvalid  = 1'b1;
        cache_i.data_rdata   = 64'hA5;
        @(negedge clk_i);
        checks++; if (rvs() !== onehot(0)) $display("FAIL rst_first_rvalid: got %b want %b", rvs(), onehot(0)); else passed++;
        checks++; if (rsp_o[1].data_rdata !== 64'hA5) $display("FAIL rst_rdata_bcast: got %h want a5", rsp_o[1].data_rdata); else passed++;
        tick();
        req_i   = '0;
        cache_i = '0;
    endtask

    task automatic test_round_robin();
        int exp;
        apply_reset();
        req_i[0].data_req = 1'b1;
        req_i[1].data_req = 1'b1;
        cache_i.data_gnt  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp = k % 2;
            @(negedge clk_i);
            checks++; if (gnts() !== onehot(exp)) $display("FAIL rr_gnt%0d: got %b want %b", k, gnts(), onehot(exp)); else passed++;
            tick();
            req_i[exp].tag_valid = 1'b1;
            cache_i.data_rvalid  = 1'b1;
            cache_i.data_rdata   = 64'h100 + 64'(k);
            @(negedge clk_i);
            checks++; if (rvs() !== onehot(exp)) $display("FAIL rr_rvalid%0d: got %b want %b", k, rvs(), onehot(exp)); else passed++;
            checks++; if (rsp_o[1-exp].data_rdata !== 64'h100 + 64'(k)) $display("FAIL rr_rdata%0d: got %h want %h", k, rsp_o[1-exp].data_rdata, 64'h100 + 64'(k)); else passed++;
            checks++; if (cache_o.data_req !== 1'b0) $display("FAIL rr_tag_req%0d: got %b want 0", k, cache_o.data_req); else passed++;
            tick();
            req_i[exp].tag_valid = 1'b0;
            cache_i.data_rvalid  = 1'b0;
        end
    endtask

    task automatic test_lock();
        logic [NREQ-1:0] z;
        z = '0;
        apply_reset();
        req_i[0].address_index = 12'h010;
        req_i[1].address_index = 12'h011;
        req_i[1].data_req      = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) req_i[0].data_req = 1'b1;
            @(negedge clk_i);
            checks++; if (cache_o.address_index !== 12'h011) $display("FAIL lock_idx%0d: got %h want 011", c, cache_o.address_index); else passed++;
            if (c == 0) begin
                checks++; if (gnts() !== z) $display("FAIL lock_nognt: got %b want %b", gnts(), z); else passed++;
            end
            tick();
        end
        cache_i.data_gnt = 1'b1;
        @(negedge clk_i);
        checks++; if (gnts() !== onehot(1)) $display("FAIL lock_gnt: got %b want %b", gnts(), onehot(1)); else passed++;
        tick();
        req_i[1].data_req   = 1'b0;
        req_i[1].tag_valid  = 1'b1;
        cache_i.data_rvalid = 1'b1;
        @(negedge clk_i);
        checks++; if (rvs() !== onehot(1)) $display("FAIL lock_rvalid: got %b want %b", rvs(), onehot(1)); else passed++;
        tick();
        req_i[1].tag_valid  = 1'b0;
        cache_i.data_rvalid = 1'b0;
        @(negedge clk_i);
        checks++; if (gnts() !== onehot(0)) $display("FAIL lock_next_gnt: got %b want %b", gnts(), onehot(0)); else passed++;
    endtask

    task automatic test_kill();
        logic [NREQ-1:0] z;
        z = '0;
        apply_reset();
        req_i[0].data_req = 1'b1;
        req_i[1].data_req = 1'b1;
        cache_i.data_gnt  = 1'b1;
        @(negedge clk_i);
        checks++; if (gnts() !== onehot(0)) $display("FAIL kill_gnt0: got %b want %b", gnts(), onehot(0)); else passed++;
        tick();
        req_i[0].kill_req   = 1'b1;
        req_i[0].tag_valid  = 1'b1;
        cache_i.data_rvalid = 1'b1;
        @(negedge clk_i);
        checks++; if (cache_o.kill_req !== 1'b1) $display("FAIL kill_fwd: got %b want 1", cache_o.kill_req); else passed++;
        checks++; if (rvs() !== z) $display("FAIL kill_rvalid: got %b want %b", rvs(), z); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL kill_busy_tag: got %b want 1", busy); else passed++;
        tick();
        req_i[0].kill_req   = 1'b0;
        req_i[0].tag_valid  = 1'b0;
        cache_i.data_rvalid = 1'b0;
        @(negedge clk_i);
        checks++; if (busy !== 1'b0) $display("FAIL kill_idle: got %b want 0", busy); else passed++;
        checks++; if (gnts() !== onehot(1)) $display("FAIL kill_gnt1: got %b want %b", gnts(), onehot(1)); else passed++;
        checks++; if (rvs() !== z) $display("FAIL kill_no_rvalid: got %b want %b", rvs(), z); else passed++;
    endtask

    task automatic test_miss();
        logic [NREQ-1:0] z;
        z = '0;
        apply_reset();
        req_i[0].data_req = 1'b1;
        req_i[1].data_req = 1'b1;
        cache_i.data_gnt  = 1'b1;
        @(negedge clk_i);
        checks++; if (gnts() !== onehot(0)) $display("FAIL miss_gnt0: got %b want %b", gnts(), onehot(0)); else passed++;
        tick();
        req_i[0].tag_valid   = 1'b1;
        req_i[0].address_tag = 44'h123_4567_89AB;
        @(negedge clk_i);
        checks++; if (cache_o.tag_valid !== 1'b1) $display("FAIL miss_tag_valid: got %b want 1", cache_o.tag_valid); else passed++;
        checks++; if (cache_o.address_tag !== 44'h123_4567_89AB) $display("FAIL miss_tag: got %h want 123456789ab", cache_o.address_tag); else passed++;
        tick();
        req_i[0].tag_valid = 1'b0;
        for (int c = 1; c < 10; c++) begin
            @(negedge clk_i);
            checks++;
            if ({busy, gnts(), rvs()} !== {1'b1, z, z})
                $display("FAIL miss_wait%0d: got busy=%b gnt=%b rvalid=%b want busy=1 gnt=0 rvalid=0", c, busy, gnts(), rvs());
            else passed++;
            tick();
        end
        cache_i.data_rvalid = 1'b1;
        cache_i.data_rdata  = 64'hDEADBEEF_CAFEF00D;
        @(negedge clk_i);
        checks++; if (rvs() !== onehot(0)) $display("FAIL miss_rvalid: got %b want %b", rvs(), onehot(0)); else passed++;
        checks++; if (rsp_o[0].data_rdata !== 64'hDEADBEEF_CAFEF00D) $display("FAIL miss_rdata: got %h want deadbeefcafef00d", rsp_o[0].data_rdata); else passed++;
        checks++; if (gnts() !== z) $display("FAIL miss_resp_gnt: got %b want %b", gnts(), z); else passed++;
        tick();
        cache_i.data_rvalid = 1'b0;
        @(negedge clk_i);
        checks++; if (gnts() !== onehot(1)) $display("FAIL miss_next_gnt: got %b want %b", gnts(), onehot(1)); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL miss_busy_idle: got %b want 0", busy); else passed++;
    endtask

`ifdef WT_DCACHE_RD_ARB_STARVE_EN
    task automatic test_starve();
        apply_reset();
        for (int i = 0; i < NREQ; i++) req_i[i].address_index = DCACHE_INDEX_WIDTH'(i);
        req_i[0].data_req = 1'b1;
        req_i[2].data_req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            checks++; if (cache_o.address_index !== 12'h000) $display("FAIL starve_lock%0d: got %h want 000", c, cache_o.address_index); else passed++;
            tick();
        end
        cache_i.data_gnt = 1'b1;
        @(negedge clk_i);
        checks++; if (gnts() !== onehot(0)) $display("FAIL starve_lock_kept: got %b want %b", gnts(), onehot(0)); else passed++;
        tick();
        req_i[0].data_req   = 1'b0;
        req_i[0].tag_valid  = 1'b1;
        req_i[1].data_req   = 1'b1;
        cache_i.data_rvalid = 1'b1;
        @(negedge clk_i);
        checks++; if (rvs() !== onehot(0)) $display("FAIL starve_rvalid: got %b want %b", rvs(), onehot(0)); else passed++;
        tick();
        req_i[0].tag_valid  = 1'b0;
        cache_i.data_rvalid = 1'b0;
        @(negedge clk_i);
        checks++; if (gnts() !== onehot(2)) $display("FAIL starve_gnt2: got %b want %b", gnts(), onehot(2)); else passed++;
    endtask
`endif

    initial begin
        req_i   = '0;
        cache_i = '0;
        test_reset();
        test_round_robin();
        test_lock();
        test_kill();
        test_miss();
`ifdef WT_DCACHE_RD_ARB_STARVE_EN
        test_starve();
`endif
        apply_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
